// File: rtl/gpu_pkg.sv
// Shared definitions for the double-buffered rectangle record store:
// record field offsets and the clear-engine state type.
package gpu_pkg;

  localparam int unsigned REC_EN    = 0;
  localparam int unsigned REC_X     = 1;
  localparam int unsigned REC_Y     = 2;
  localparam int unsigned REC_W     = 3;
  localparam int unsigned REC_H     = 4;
  localparam int unsigned REC_COLOR = 5;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } clr_state_e;

endpackage

// File: rtl/gpu_bank_ram.sv
// Single-clock simple dual-port RAM: one write port, one registered read port.
// Contents are not reset.
module gpu_bank_ram #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/gpu_rect_mem.sv
// Double-buffered rectangle record memory: GPU reads the front bank, CPU and
// the record-clear engine write the back bank; swaps happen at frame boundaries.
module gpu_rect_mem
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned RECT_COUNT = 64,
  parameter int unsigned RECT_WORDS = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              clr_req,
  output logic              busy,
  output logic              wr_drop,
  output logic              front_bank
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned IW = (RECT_COUNT > 1) ? $clog2(RECT_COUNT) : 1;
  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(RECT_COUNT - 1);
  localparam logic [AW-1:0]   STRIDE   = AW'(RECT_WORDS);
  localparam logic [AW-1:0]   EN_OFF   = AW'(REC_EN);

  if (RECT_COUNT * RECT_WORDS > DEPTH) begin : g_fit_check
    $error("gpu_rect_mem: RECT_COUNT*RECT_WORDS exceeds DEPTH");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_pow2_check
    $error("gpu_rect_mem: DEPTH must be a power of two");
  end
  if (ADDR_W < AW) begin : g_addr_check
    $error("gpu_rect_mem: ADDR_W too narrow for DEPTH");
  end

  clr_state_e        state_q, state_d;
  logic [IW-1:0]     clr_idx_q, clr_idx_d;
  logic [AW-1:0]     clr_addr_q, clr_addr_d;
  logic              pend_q, pend_d;
  logic              front_q, front_d;
  logic              busy_q, busy_d;
  logic              swap_ack_q, swap_ack_d;
  logic              wr_drop_q, wr_drop_d;
  logic              rd_bank_q, rd_bank_d;
  logic              rd_zero_q, rd_zero_d;

  logic              rd_in_range, wr_in_range;
  logic              ram_we, clr_we;
  logic [AW-1:0]     ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] q0, q1;

  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    clr_addr_d = clr_addr_q;
    pend_d     = pend_q;
    front_d    = front_q;
    busy_d     = busy_q;
    swap_ack_d = 1'b0;

    rd_in_range = {1'b0, rd_addr} < DEPTH_X;
    wr_in_range = {1'b0, wr_addr} < DEPTH_X;
    rd_bank_d   = front_q;
    rd_zero_d   = !rd_in_range;
    wr_drop_d   = wr_en && (busy_q || !wr_in_range);

    clr_we    = (state_q == ST_CLEAR);
    ram_we    = clr_we || (wr_en && !busy_q && wr_in_range);
    ram_waddr = clr_we ? clr_addr_q : wr_addr[AW-1:0];
    ram_wdata = clr_we ? '0 : wr_data;

    case (state_q)
      ST_IDLE: begin
        // Swap is applied before the clear starts, so the clear hits the new back bank.
        if (swap_req) begin
          front_d    = ~front_q;
          swap_ack_d = 1'b1;
        end
        if (clr_req) begin
          state_d    = ST_CLEAR;
          busy_d     = 1'b1;
          clr_idx_d  = '0;
          clr_addr_d = EN_OFF;
        end
      end
      ST_CLEAR: begin
        clr_idx_d  = clr_idx_q + 1'b1;
        clr_addr_d = clr_addr_q + STRIDE;
        if (swap_req) begin
          pend_d = 1'b1;
        end
        if (clr_idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          if (pend_q || swap_req) begin
            front_d    = ~front_q;
            swap_ack_d = 1'b1;
            pend_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      clr_idx_q  <= '0;
      clr_addr_q <= EN_OFF;
      pend_q     <= 1'b0;
      front_q    <= 1'b0;
      busy_q     <= 1'b0;
      swap_ack_q <= 1'b0;
      wr_drop_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      rd_zero_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      clr_addr_q <= clr_addr_d;
      pend_q     <= pend_d;
      front_q    <= front_d;
      busy_q     <= busy_d;
      swap_ack_q <= swap_ack_d;
      wr_drop_q  <= wr_drop_d;
      rd_bank_q  <= rd_bank_d;
      rd_zero_q  <= rd_zero_d;
    end
  end

  gpu_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_bank0 (
    .clk   (clk),
    .we    (ram_we && front_q),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr[AW-1:0]),
    .rdata (q0)
  );

  gpu_bank_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_bank1 (
    .clk   (clk),
    .we    (ram_we && !front_q),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rd_addr[AW-1:0]),
    .rdata (q1)
  );

  // The RAMs have no reset, so the zero flag forces rd_data low out of reset too.
  always_comb begin
    rd_data = rd_zero_q ? '0 : (rd_bank_q ? q1 : q0);
  end

  assign swap_ack   = swap_ack_q;
  assign busy       = busy_q;
  assign wr_drop    = wr_drop_q;
  assign front_bank = front_q;

endmodule
